// File: rtl/paddle_pkg.sv
// Shared definitions for the multi-paddle controller: per-paddle FSM state
// encoding, default screen geometry and speed limits.
package paddle_pkg;

  // Default geometry (pixels)
  localparam int SCREEN_H_DEF    = 480;
  localparam int HALF_SMALL_DEF  = 40;
  localparam int HALF_LARGE_DEF  = 50;

  // Default timing and speed limits
  localparam int TICK_DIV_DEF    = 131072;
  localparam int MAX_SPEED_DEF   = 4;
  localparam int ACCEL_TICKS_DEF = 8;

  // Per-paddle movement state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } paddle_state_e;

endpackage

// File: rtl/paddle_axis.sv
// One paddle: button synchronisers, IDLE/UP/DOWN FSM with hold-to-accelerate
// speed control, and a saturating position register clamped to [lo, hi].
module paddle_axis
  import paddle_pkg::*;
#(
  parameter int Y_WIDTH     = 10,
  parameter int SCREEN_H    = SCREEN_H_DEF,
  parameter int MAX_SPEED   = MAX_SPEED_DEF,
  parameter int ACCEL_TICKS = ACCEL_TICKS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_plus_n,
  input  logic               btn_minus_n,
  input  logic               tick,
  input  logic               centre,
  input  logic [Y_WIDTH-1:0] lo,
  input  logic [Y_WIDTH-1:0] hi,
  output logic [Y_WIDTH-1:0] pos,
  output logic               at_min,
  output logic               at_max
);

  localparam int SPD_W  = $clog2(MAX_SPEED + 1);
  localparam int HOLD_W = $clog2(ACCEL_TICKS + 1);
  localparam logic [Y_WIDTH-1:0] POS_CENTRE = Y_WIDTH'(SCREEN_H / 2);

  // One extra bit so pos +/- speed can go below zero or past the top
  // before it is clamped, instead of wrapping.
  typedef logic signed [Y_WIDTH:0] ext_t;

  // Button pairs are packed {plus, minus}, still active-low.
  logic [1:0]          meta_q, meta_d;
  logic [1:0]          sync_q, sync_d;
  logic                plus_pressed, minus_pressed;

  paddle_state_e       state_q, state_d;
  logic [SPD_W-1:0]    speed_q, speed_d;
  logic [HOLD_W-1:0]   hold_q, hold_d, hold_inc;
  logic [Y_WIDTH-1:0]  pos_q, pos_d;
  logic                at_min_q, at_min_d;
  logic                at_max_q, at_max_d;
  ext_t                delta, sum;

  // Two-stage synchroniser input chain
  always_comb begin
    meta_d = {btn_plus_n, btn_minus_n};
    sync_d = meta_q;
  end

  // Synchroniser flops
  // NOTE: sequential state is written with non-blocking (<=) so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: synchroniser flops reset to 1 (released) because the buttons
      // are active-low; resetting to 0 would look like a press.
      meta_q <= 2'b11;
      sync_q <= 2'b11;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign plus_pressed  = ~sync_q[1];
  assign minus_pressed = ~sync_q[0];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: decided only on tick; recentre forces IDLE
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    state_d = state_q;
    if (centre) begin
      state_d = ST_IDLE;
    end else if (tick) begin
      unique case ({plus_pressed, minus_pressed})
        2'b10:   state_d = ST_UP;
        2'b01:   state_d = ST_DOWN;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: speed/hold update and signed step for this tick
  always_comb begin
    speed_d  = speed_q;
    hold_d   = hold_q;
    hold_inc = hold_q + 1'b1;
    delta    = '0;
    if (centre) begin
      speed_d = SPD_W'(1);
      hold_d  = '0;
    end else if (tick) begin
      if (state_d == ST_IDLE || state_d != state_q) begin
        // Fresh press or change of direction restarts the acceleration
        speed_d = SPD_W'(1);
        hold_d  = '0;
      end else if (hold_inc == HOLD_W'(ACCEL_TICKS)) begin
        hold_d = '0;
        if (speed_q < SPD_W'(MAX_SPEED)) begin
          speed_d = speed_q + 1'b1;
        end
      end else begin
        hold_d = hold_inc;
      end
      // The step uses the speed already updated for this tick
      if (state_d == ST_UP) begin
        delta = ext_t'(speed_d);
      end else if (state_d == ST_DOWN) begin
        delta = -ext_t'(speed_d);
      end
    end
  end

  // Position: apply step, then clamp into [lo, hi] every cycle
  always_comb begin
    sum   = ext_t'(pos_q) + delta;
    pos_d = pos_q;
    if (centre) begin
      pos_d = POS_CENTRE;
    end else if (sum < ext_t'(lo)) begin
      pos_d = lo;
    end else if (sum > ext_t'(hi)) begin
      pos_d = hi;
    end else begin
      pos_d = sum[Y_WIDTH-1:0];
    end
    at_min_d = (pos_d == lo);
    at_max_d = (pos_d == hi);
  end

  // Speed, hold, position and bound-flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_q  <= SPD_W'(1);
      hold_q   <= '0;
      pos_q    <= POS_CENTRE;
      at_min_q <= 1'b0;
      at_max_q <= 1'b0;
    end else begin
      speed_q  <= speed_d;
      hold_q   <= hold_d;
      pos_q    <= pos_d;
      at_min_q <= at_min_d;
      at_max_q <= at_max_d;
    end
  end

  assign pos    = pos_q;
  assign at_min = at_min_q;
  assign at_max = at_max_q;

endmodule

// File: rtl/paddle_controller_multi.sv
// Multi-paddle controller top: shared movement-tick prescaler, size-dependent
// bounds, and one paddle_axis per paddle.
module paddle_controller_multi
  import paddle_pkg::*;
#(
  parameter int NUM_PADDLES = 2,
  parameter int Y_WIDTH     = 10,
  parameter int SCREEN_H    = SCREEN_H_DEF,
  parameter int HALF_SMALL  = HALF_SMALL_DEF,
  parameter int HALF_LARGE  = HALF_LARGE_DEF,
  parameter int TICK_DIV    = TICK_DIV_DEF,
  parameter int MAX_SPEED   = MAX_SPEED_DEF,
  parameter int ACCEL_TICKS = ACCEL_TICKS_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PADDLES-1:0]         btn_plus_n,
  input  logic [NUM_PADDLES-1:0]         btn_minus_n,
  input  logic                           bat_size,
  input  logic                           centre,
  output logic [NUM_PADDLES*Y_WIDTH-1:0] pos_y,
  output logic [NUM_PADDLES-1:0]         at_min,
  output logic [NUM_PADDLES-1:0]         at_max
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick;
  logic [Y_WIDTH-1:0] lo, hi;

  // Prescaler: count 0..TICK_DIV-1, tick on the last count
  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Prescaler register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Bounds follow the currently selected paddle size
  always_comb begin
    if (bat_size) begin
      lo = Y_WIDTH'(HALF_SMALL);
      hi = Y_WIDTH'(SCREEN_H - HALF_SMALL);
    end else begin
      lo = Y_WIDTH'(HALF_LARGE);
      hi = Y_WIDTH'(SCREEN_H - HALF_LARGE);
    end
  end

  for (genvar i = 0; i < NUM_PADDLES; i++) begin : g_paddle
    paddle_axis #(
      .Y_WIDTH    (Y_WIDTH),
      .SCREEN_H   (SCREEN_H),
      .MAX_SPEED  (MAX_SPEED),
      .ACCEL_TICKS(ACCEL_TICKS)
    ) u_axis (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_plus_n (btn_plus_n[i]),
      .btn_minus_n(btn_minus_n[i]),
      .tick       (tick),
      .centre     (centre),
      .lo         (lo),
      .hi         (hi),
      .pos        (pos_y[i*Y_WIDTH +: Y_WIDTH]),
      .at_min     (at_min[i]),
      .at_max     (at_max[i])
    );
  end

endmodule

// File: tb/tb_paddle_controller_multi.sv
// Self-checking bench for paddle_controller_multi with TICK_DIV=4: directed
// scenarios with literal expectations plus randomized stimulus compared every
// cycle against a behavioural model of the paddles.
module tb_paddle_controller_multi;

  localparam int NP = 2;
  localparam int YW = 10;
  localparam int SH = 480;
  localparam int HS = 40;
  localparam int HL = 50;
  localparam int TD = 4;
  localparam int MS = 4;
  localparam int AT = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NP-1:0]    btn_plus_n = '1;
  logic [NP-1:0]    btn_minus_n = '1;
  logic             bat_size = 1'b0;
  logic             centre = 1'b0;
  logic [NP*YW-1:0] pos_y;
  logic [NP-1:0]    at_min;
  logic [NP-1:0]    at_max;

  paddle_controller_multi #(
    .NUM_PADDLES(NP),
    .Y_WIDTH    (YW),
    .SCREEN_H   (SH),
    .HALF_SMALL (HS),
    .HALF_LARGE (HL),
    .TICK_DIV   (TD),
    .MAX_SPEED  (MS),
    .ACCEL_TICKS(AT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_plus_n (btn_plus_n),
    .btn_minus_n(btn_minus_n),
    .bat_size   (bat_size),
    .centre     (centre),
    .pos_y      (pos_y),
    .at_min     (at_min),
    .at_max     (at_max)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int dut_pos(int i);
    return int'(pos_y[i*YW +: YW]);
  endfunction

  // ---------------- behavioural model ----------------
  // Buttons seen by the control logic are the inputs delayed by two clocks.
  bit m_d1p[NP], m_d2p[NP], m_d1m[NP], m_d2m[NP];
  int m_pos[NP], m_dir[NP], m_spd[NP], m_hold[NP];
  bit m_amin[NP], m_amax[NP];
  int m_cnt;
  int m_ticks = 0;

  function automatic void model_reset();
    for (int i = 0; i < NP; i++) begin
      m_d1p[i] = 1'b1; m_d2p[i] = 1'b1; m_d1m[i] = 1'b1; m_d2m[i] = 1'b1;
      m_pos[i] = SH / 2; m_dir[i] = 0; m_spd[i] = 1; m_hold[i] = 0;
      m_amin[i] = 1'b0; m_amax[i] = 1'b0;
    end
    m_cnt = 0;
  endfunction

  function automatic void model_step();
    int lo = bat_size ? HS : HL;
    int hi = SH - lo;
    bit tk = (m_cnt == TD - 1);
    for (int i = 0; i < NP; i++) begin
      bit plus = !m_d2p[i];
      bit minus = !m_d2m[i];
      if (centre) begin
        m_pos[i] = SH / 2; m_dir[i] = 0; m_spd[i] = 1; m_hold[i] = 0;
      end else begin
        if (tk) begin
          int ndir = (plus && !minus) ? 1 : ((minus && !plus) ? -1 : 0);
          if (ndir == 0 || ndir != m_dir[i]) begin
            m_spd[i] = 1; m_hold[i] = 0;
          end else begin
            m_hold[i]++;
            if (m_hold[i] == AT) begin
              m_hold[i] = 0;
              if (m_spd[i] < MS) m_spd[i]++;
            end
          end
          m_dir[i] = ndir;
          m_pos[i] += ndir * m_spd[i];
        end
        if (m_pos[i] < lo) m_pos[i] = lo;
        if (m_pos[i] > hi) m_pos[i] = hi;
      end
      m_amin[i] = (m_pos[i] == lo);
      m_amax[i] = (m_pos[i] == hi);
    end
    for (int i = 0; i < NP; i++) begin
      m_d2p[i] = m_d1p[i]; m_d1p[i] = btn_plus_n[i];
      m_d2m[i] = m_d1m[i]; m_d1m[i] = btn_minus_n[i];
    end
    if (tk) m_ticks++;
    m_cnt = tk ? 0 : m_cnt + 1;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < NP; i++) begin
          check($sformatf("model_pos%0d", i), dut_pos(i), m_pos[i]);
          check($sformatf("model_at_min%0d", i), int'(at_min[i]), int'(m_amin[i]));
          check($sformatf("model_at_max%0d", i), int'(at_max[i]), int'(m_amax[i]));
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_ticks(int n);
    int target = m_ticks + n;
    int budget = 0;
    while (m_ticks < target && budget < 100 * TD) begin
      @(negedge clk);
      budget++;
    end
    check("tick_wait", m_ticks, target);
  endtask

  task automatic wait_pos(int i, int val, int budget);
    int n = 0;
    while (dut_pos(i) != val && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("reach_pos%0d", i), dut_pos(i), val);
  endtask

  task automatic wait_sync();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // Reset state, checked while reset is still asserted
    #22;
    for (int i = 0; i < NP; i++) begin
      check($sformatf("rst_pos%0d", i), dut_pos(i), 240);
      check($sformatf("rst_at_min%0d", i), int'(at_min[i]), 0);
      check($sformatf("rst_at_max%0d", i), int'(at_max[i]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Idle for 100 clocks
    repeat (100) @(negedge clk);
    for (int i = 0; i < NP; i++) begin
      check($sformatf("idle_pos%0d", i), dut_pos(i), 240);
      check($sformatf("idle_flags%0d", i), int'({at_min[i], at_max[i]}), 0);
    end

    // Paddle 0 plus held: 8 ticks at speed 1, then speed 2
    wait_ticks(1);
    btn_plus_n[0] = 1'b0;
    wait_sync();
    wait_ticks(8);
    check("accel_8ticks", dut_pos(0), 248);
    wait_ticks(1);
    check("accel_9ticks", dut_pos(0), 250);
    btn_plus_n[0] = 1'b1;
    check("accel_p1_still", dut_pos(1), 240);

    // Paddle 1 minus to the lower bound (bat_size=0 -> lo=50)
    bat_size = 1'b0;
    wait_ticks(1);
    btn_minus_n[1] = 1'b0;
    wait_pos(1, 50, 600);
    check("sat_at_min", int'(at_min[1]), 1);
    wait_ticks(3);
    check("sat_hold_pos", dut_pos(1), 50);
    btn_minus_n[1] = 1'b1;

    // Both buttons on paddle 0: no movement; then a single press moves by 1
    wait_ticks(1);
    btn_plus_n[0] = 1'b0;
    btn_minus_n[0] = 1'b0;
    wait_sync();
    wait_ticks(10);
    check("both_pos", dut_pos(0), 250);
    btn_minus_n[0] = 1'b1;
    wait_sync();
    wait_ticks(1);
    check("both_then_speed1", dut_pos(0), 251);
    btn_plus_n[0] = 1'b1;

    // Paddle 0 to 440 with small bat, then switch to large bat -> 430
    wait_ticks(1);
    bat_size = 1'b1;
    btn_plus_n[0] = 1'b0;
    wait_pos(0, 440, 800);
    btn_plus_n[0] = 1'b1;
    repeat (4) @(negedge clk);
    check("small_at_max", int'(at_max[0]), 1);
    bat_size = 1'b0;
    @(negedge clk);
    check("resize_pos", dut_pos(0), 430);
    check("resize_at_max", int'(at_max[0]), 1);

    // Paddle 1 up to speed 3, then centre pulse
    wait_ticks(1);
    btn_plus_n[1] = 1'b0;
    wait_sync();
    wait_ticks(17);
    check("speed3_pos", dut_pos(1), 77);
    centre = 1'b1;
    @(negedge clk);
    centre = 1'b0;
    check("centre_pos1", dut_pos(1), 240);
    check("centre_pos0", dut_pos(0), 240);
    check("centre_at_min1", int'(at_min[1]), 0);
    wait_ticks(1);
    check("centre_then_speed1", dut_pos(1), 241);
    btn_plus_n[1] = 1'b1;

    // Reset mid-movement, then first tick TICK_DIV clocks after release
    btn_plus_n = '0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NP; i++) begin
      check($sformatf("async_rst_pos%0d", i), dut_pos(i), 240);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_no_tick", dut_pos(0), 240);
    @(negedge clk);
    check("post_rst_first_tick", dut_pos(0), 241);
    btn_plus_n = '1;

    // Randomized activity on all paddles, checked by the model every cycle
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      centre = 1'b0;
      if (c == 2000) rst_n = 1'b0;
      if (c == 2003) rst_n = 1'b1;
      for (int i = 0; i < NP; i++) begin
        if ($urandom_range(0, 11) == 0) begin
          btn_plus_n[i]  = 1'($urandom_range(0, 1));
          btn_minus_n[i] = 1'($urandom_range(0, 1));
        end
      end
      if ($urandom_range(0, 199) == 0) bat_size = ~bat_size;
      if ($urandom_range(0, 299) == 0) centre = 1'b1;
    end
    centre = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/paddle_controller_multi.md
PADDLE_CONTROLLER_MULTI -- requirements
Module: paddle_controller_multi

Interface
REQ-001 SHALL have parameter NUM_PADDLES, default 2, number of independent paddles.
REQ-002 SHALL have parameter Y_WIDTH, default 10, position width in bits.
REQ-003 SHALL have parameter SCREEN_H, default 480, vertical extent in pixels.
REQ-004 SHALL have parameter HALF_SMALL, default 40, paddle half-height when bat_size=1.
REQ-005 SHALL have parameter HALF_LARGE, default 50, paddle half-height when bat_size=0.
REQ-006 SHALL have parameter TICK_DIV, default 131072, clocks per movement tick.
REQ-007 SHALL have parameter MAX_SPEED, default 4, maximum pixels moved per tick.
REQ-008 SHALL have parameter ACCEL_TICKS, default 8, consecutive held ticks per speed increment.
REQ-009 SHALL have port clk, input, 1, single clock, rising edge.
REQ-010 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-011 SHALL have port btn_plus_n, input, NUM_PADDLES, active-low increase button, asynchronous, one bit per paddle.
REQ-012 SHALL have port btn_minus_n, input, NUM_PADDLES, active-low decrease button, asynchronous, one bit per paddle.
REQ-013 SHALL have port bat_size, input, 1, paddle size select.
REQ-014 SHALL have port centre, input, 1, synchronous one-cycle recentre request.
REQ-015 SHALL have port pos_y, output, NUM_PADDLES*Y_WIDTH, packed centre positions, paddle i in bits [i*Y_WIDTH +: Y_WIDTH].
REQ-016 SHALL have port at_min, output, NUM_PADDLES, paddle i at its lower bound.
REQ-017 SHALL have port at_max, output, NUM_PADDLES, paddle i at its upper bound.

Function
REQ-018 Each button bit SHALL pass a 2-flop synchroniser; control logic uses synchronised values only (2-cycle input latency).
REQ-019 Prescaler SHALL count 0..TICK_DIV-1 and wrap; tick asserts for one clk when count = TICK_DIV-1.
REQ-020 Bounds SHALL be lo = half, hi = SCREEN_H - half, with half = HALF_SMALL if bat_size else HALF_LARGE.
REQ-021 Each paddle SHALL run an FSM with states IDLE, UP, DOWN, updated only on tick.
REQ-022 On tick, plus-only pressed SHALL go to UP; minus-only pressed SHALL go to DOWN; neither or both pressed SHALL go to IDLE (no movement).
REQ-023 On entry to UP or DOWN from any other state, speed SHALL be 1 and hold count 0.
REQ-024 While remaining in UP/DOWN, hold count SHALL increment each tick; at ACCEL_TICKS it resets to 0 and speed increments, saturating at MAX_SPEED.
REQ-025 Movement SHALL apply on the tick the state is UP/DOWN: pos += speed (UP) or pos -= speed (DOWN).
REQ-026 Arithmetic SHALL use Y_WIDTH+1 signed intermediate; result saturates to [lo, hi] with no wrap and no overshoot.
REQ-027 Every cycle, a position outside [lo, hi] (e.g. after bat_size change) SHALL be clamped to the nearest bound on the next clk, independent of tick.
REQ-028 centre=1 SHALL set every pos to SCREEN_H/2, FSM to IDLE, speed 1, hold 0 on the next clk, overriding movement and tick.
REQ-029 at_min/at_max SHALL be registered, true when pos = lo / pos = hi, updated with pos.
REQ-030 Paddles SHALL be fully independent; simultaneous activity on all paddles SHALL be handled in the same tick.

Reset
REQ-031 rst_n low SHALL asynchronously set all pos to SCREEN_H/2 (240), FSMs IDLE, speed 1, hold 0, prescaler 0, synchronisers to released (1), at_min/at_max 0.
REQ-032 Reset asserted mid-movement SHALL abort immediately; first tick after release occurs TICK_DIV clks later.

Structure
REQ-033 FSM state enum, default geometry constants (SCREEN_H, halves) and speed limits SHALL live in a shared package paddle_pkg.
REQ-034 Per-paddle synchroniser, FSM, speed and position logic SHALL be sub-module paddle_axis, instantiated NUM_PADDLES times via generate; prescaler shared at top.

Verification (TICK_DIV=4, defaults otherwise)
REQ-035 Reset release, no buttons, 100 clks -> pos_y all 240, at_min/at_max 0.
REQ-036 Paddle 0 plus held 9 ticks -> moves 1/tick for 8 ticks, then speed 2: pos 240->248->250.
REQ-037 Paddle 1 minus held until saturation with bat_size=0 -> pos stops exactly at 50, at_min=1, never below.
REQ-038 Both buttons paddle 0 held 10 ticks -> pos unchanged, FSM IDLE, speed stays 1.
REQ-039 Paddle 0 at 440 with bat_size=1, switch bat_size=0 -> pos 430 next clk, at_max=1.
REQ-040 centre pulse while paddle 1 moving at speed 3 -> pos 240 next clk, next movement at speed 1.
